// File: rtl/pc_control_unit.sv
// Program-counter sequencer: fetch PC with trap entry/return, redirects, stalls,
// a debug halt/resume state machine and a retired-instruction counter.
module pc_control_unit #(
  parameter int                XLEN         = 64,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'('h100),
  parameter int                IALIGN       = 32,
  parameter int                CNT_W        = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_req,
  input  logic              trap_return,
  input  logic              halt_req,
  input  logic              resume_req,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic [XLEN-1:0]   epc,
  output logic              trap_taken,
  output logic              misaligned,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [XLEN-1:0]  PC_INC  = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  logic [0:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_epc;
  logic             r_trap_taken;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_retired;

  logic             w_low_bits_set;
  logic             w_mis;
  logic [XLEN-1:0]  w_pc_plus4;

  // Alignment check depends only on which low target bits must be zero.
  generate
    if (IALIGN == 32) begin : g_align32
      assign w_low_bits_set = |redirect_target[1:0];
    end else begin : g_align16
      assign w_low_bits_set = redirect_target[0];
    end
  endgenerate

  assign w_mis      = redirect_valid & w_low_bits_set;
  assign w_pc_plus4 = r_pc + PC_INC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_trap_taken <= 1'b0;
      r_misaligned <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_trap_taken <= 1'b0;
      r_misaligned <= 1'b0;
      if (r_state == ST_RUN) begin
        if (trap_req | w_mis) begin
          r_pc         <= TRAP_VECTOR;
          r_epc        <= r_pc;
          r_trap_taken <= 1'b1;
          r_misaligned <= w_mis & ~trap_req;
        end else if (trap_return) begin
          r_pc      <= r_epc;
          r_retired <= r_retired + CNT_INC;
        end else if (halt_req) begin
          // Pending redirect is dropped; the debugger restarts from the held pc.
          r_state <= ST_HALTED;
        end else if (redirect_valid) begin
          r_pc      <= redirect_target;
          r_retired <= r_retired + CNT_INC;
        end else if (!stall) begin
          r_pc      <= w_pc_plus4;
          r_retired <= r_retired + CNT_INC;
        end
      end else if (resume_req) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign epc           = r_epc;
  assign trap_taken    = r_trap_taken;
  assign misaligned    = r_misaligned;
  assign halted        = (r_state == ST_HALTED);
  assign retired_count = r_retired;

endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
Parametrised program-counter sequencer for the RV64I core, replacing the plain PC register. It holds the fetch PC and selects the next PC by fixed priority from trap entry, trap return, branch/jump redirect, stall and sequential increment. It also detects misaligned redirect targets, keeps an exception PC (EPC), supports a debug halt/resume state machine, and counts retired instructions. It sits between the next-PC/branch logic and the instruction memory address port.

Parameters:
XLEN, 64, PC/address width in bits (32 or 64)
RESET_VECTOR, 0, PC value loaded on reset (XLEN bits, must be IALIGN-aligned)
TRAP_VECTOR, 'h100, PC loaded on any trap entry (XLEN bits, aligned)
IALIGN, 32, instruction alignment in bits: 32 means low 2 bits must be 0, 16 means bit 0 must be 0
CNT_W, 64, width of the retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC this cycle (pipeline/memory not ready)
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  XLEN  branch/jump target address
trap_req  input  1  synchronous exception/ecall request for the instruction at pc
trap_return  input  1  return from trap (mret-like), next PC = epc
halt_req  input  1  debug halt request
resume_req  input  1  debug resume request
pc  output  XLEN  current fetch PC (registered)
pc_plus4  output  XLEN  pc + 4, combinational, wraps modulo 2^XLEN
epc  output  XLEN  exception PC (registered)
trap_taken  output  1  registered one-cycle pulse: trap entered on previous edge
misaligned  output  1  registered one-cycle pulse: trap was caused by a misaligned redirect
halted  output  1  1 while in HALTED state
retired_count  output  CNT_W  retired-instruction counter

Behaviour:
- Reset (async, any time, including mid-stall or mid-halt): pc=RESET_VECTOR, epc=0, trap_taken=0, misaligned=0, halted=0, retired_count=0, state=RUN. The first rising edge after reset deasserts already uses normal RUN rules.
- States: RUN, HALTED. The halted output equals (state==HALTED).
- Misaligned target: mis = redirect_valid & (IALIGN==32 ? |redirect_target[1:0] : redirect_target[0]).
- RUN next-state priority, highest first, one winner per edge:
  1. trap_req or mis: pc<=TRAP_VECTOR, epc<=pc (address of faulting instr), trap_taken<=1, misaligned<=(mis & ~trap_req). No retire.
  2. trap_return: pc<=epc. Retire +1.
  3. halt_req: pc held, state<=HALTED. No retire. Any pending redirect is dropped; the debugger re-executes from pc.
  4. redirect_valid (aligned): pc<=redirect_target. Retire +1. This wins over stall.
  5. stall: pc held. No retire.
  6. Otherwise pc<=pc_plus4. Retire +1.
- trap_taken and misaligned are 0 on every edge where rule 1 does not fire. A nested trap overwrites epc.
- HALTED: pc, epc and retired_count are held. trap_req, trap_return, redirect_valid and stall are ignored. resume_req puts state<=RUN at the next edge, and pc is unchanged on that edge. halt_req together with resume_req in HALTED resolves as resume.
- Arithmetic: pc_plus4 and retired_count wrap silently (pc 2^XLEN-4 goes to 0; counter all-ones goes to 0). No saturation or flags.
- Latency: a redirect, trap or return presented in cycle N is visible on pc after edge N. trap_taken and misaligned are high during cycle N+1 only.
- pc is never loaded with a misaligned value.

Test Plan:
- Reset then 3 free-running cycles (XLEN=64, RESET_VECTOR=0) -> pc 0x0, 0x4, 0x8, 0xC; retired_count=3. Assert reset mid-run -> pc=0 and count=0 immediately, without waiting for a clock edge.
- At pc=0x10, assert stall for 2 cycles, then redirect_valid with target 0x40 while stall=1 -> pc holds 0x10 for 2 edges, then becomes 0x40 (redirect wins); count increases by 1 only.
- At pc=0x40, redirect_target=0x42 -> pc=0x100, epc=0x40, trap_taken=1 and misaligned=1 for exactly one cycle. With IALIGN=16, target 0x42 is taken normally and 0x43 traps.
- At pc=0x20, trap_req=1 with redirect_valid=1 (target 0x80) -> pc=0x100, epc=0x20, misaligned=0. Advance to 0x108, then trap_return -> pc=0x20.
- At pc=0x30, halt_req=1 -> halted=1 and pc stays 0x30 for 5 cycles despite redirect/trap_req stimulus; count is frozen. resume_req -> halted=0 and pc=0x30, then 0x34 on the next edge.
- Wrap: XLEN=32, redirect to 0xFFFFFFFC, then a free cycle -> pc=0x0. With CNT_W=4, 16 retires -> retired_count returns to 0.
